instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch and PC sequencing unit for the MIPS core. It owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. It presents the fetched word and its OpCode/Funct fields to the control decoder and datapath. It then consumes the decoder's PCSrc/Branch outputs, together with the ALU zero flag and rs data, to compute the next PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned-target exception (only with IFETCH_ALIGN_CHECK_EN).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals PC.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack.
- instr_valid  out  1  Instruction/OpCode/Funct hold a fetched instruction.
- Instruction  out  32  registered instruction word.
- OpCode  out  6  Instruction[31:26].
- Funct  out  6  Instruction[5:0].
- PC  out  32  address of the current instruction.
- PC_plus4  out  32  PC+4, the link value for jal/jalr.
- exec_done  in  1  datapath finished the current instruction; next-PC inputs are valid this cycle.
- PCSrc  in  2  from the control decoder: 00 sequential/branch, 01 jump, 10 register jump, 11 reserved.
- Branch  in  1  from the control decoder.
- Zero  in  1  ALU equality result.
- RsData  in  32  register rs value for jr/jalr.
- retired  out  32  count of completed instructions.
- exc  out  1  one-cycle exception pulse (tied 0 without the macro).

## Operation
- FSM states:
  - IDLE, the reset state.
  - FETCH: imem_req=1, imem_addr=PC.
  - ISSUE: instr_valid=1.
- Transitions:
  - IDLE→FETCH unconditionally on the first edge after reset release.
  - FETCH→ISSUE on an edge with imem_ack=1; Instruction<=imem_rdata.
  - ISSUE→FETCH on an edge with exec_done=1; PC<=next_pc and retired<=retired+1.
- imem_req and imem_addr are held stable until ack. imem_ack is ignored outside FETCH. exec_done is ignored outside ISSUE.
- next_pc, computed mod 2^32:
  - PCSrc=00: if Branch&Zero, PC_plus4 + (sext(Instruction[15:0])<<2); otherwise PC_plus4.
  - PCSrc=01: {PC_plus4[31:28], Instruction[25:0], 2'b00}.
  - PCSrc=10: RsData.
  - PCSrc=11: PC_plus4.
- Branch with PCSrc≠00 is ignored.
- retired wraps from 32'hFFFF_FFFF to 0.
- Reset values:
  - state IDLE, PC=RESET_PC, Instruction=0, retired=0.
  - imem_req=0, instr_valid=0, exc=0.
  - OpCode/Funct=0 and PC_plus4=RESET_PC+4, all derived.
- Reset asserted mid-operation, whether a fetch is outstanding or an instruction is issued: all state returns immediately to reset values. A late imem_ack after reset release is ignored, because the state is IDLE.

## Timing
- Steady state: one instruction per 1 (ack) + N (exec_done) handshakes. The minimum loop is 2 cycles per instruction, given zero-wait memory (ack in the first FETCH cycle) and exec_done in the first ISSUE cycle.
- instr_valid rises in the cycle after the ack edge.
- imem_req rises in the cycle after the exec_done edge, already carrying the new PC.
- First imem_req is visible 1 cycle after reset_n deasserts (after the IDLE edge).
- All outputs are registered or derived purely from registers, except imem_addr=PC. There is no combinational path from inputs to outputs.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - A next_pc with bits [1:0]≠0 on the exec_done edge loads EXC_VECTOR instead.
  - exc pulses high for one cycle, the cycle after that edge.
  - retired still increments.
- Not defined: next_pc is loaded unchanged, including low bits. The fetch address is then misaligned, and exc is constant 0.

## Structure
- Shared package cpu_pkg holds:
  - the fetch state enum (IDLE/FETCH/ISSUE);
  - PCSrc encodings PCSRC_SEQ=2'b00, PCSRC_J=2'b01, PCSRC_JR=2'b10;
  - default RESET_PC/EXC_VECTOR constants.
- One sub-module, next_pc_calc: purely combinational. Inputs are PC_plus4, Instruction, PCSrc, Branch, Zero and RsData; outputs are next_pc and misaligned. The FSM, PC register and counter stay in instr_fetch.

## Test plan
- Reset/boot:
  - Hold reset_n=0 for 3 cycles, then release → imem_req=0 and instr_valid=0 during reset.
  - imem_req=1 with imem_addr=0 one cycle after release.
- Sequential:
  - Zero-wait ack, exec_done each ISSUE, PCSrc=00, Branch=0 → imem_addr sequence 0,4,8,C.
  - One instruction per 2 cycles; retired=4 after the fourth exec_done.
- Branch:
  - PC=0x10, Instruction imm=16'hFFFC, Branch=1, Zero=1 → next fetch address 0x04.
  - Same case with Zero=0 → 0x14.
- Jump/jr:
  - PC=0x3000_0000, Instruction[25:0]=26'h0000040, PCSrc=01 → 0x3000_0100.
  - PCSrc=10 with RsData=0x0000_0200 → 0x200.
- Wait states and reset mid-fetch:
  - Ack delayed by 3 cycles → imem_addr is stable through the wait and instr_valid rises only after the ack.
  - reset_n pulsed low during FETCH → imem_req drops immediately and PC=RESET_PC.
- Align check (macro on): PCSrc=10 with RsData=0x0000_0202 → next imem_addr=0x80, exc high for exactly one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and constants: fetch FSM encoding, PCSrc codes, default vectors.
// The branch-offset helper keeps the sign-extend-and-scale rule in one place.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_ISSUE = 2'd2
    } fetch_state_e;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ack bus. The fetch unit is master; the memory is slave.
// req/addr are held stable by the master until ack; rdata is valid only with ack.
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational next-PC selection from decoder PCSrc/Branch, ALU Zero and rs data.
// No state and no handshake; the result is sampled by the fetch FSM on the exec_done edge.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] PC_plus4,
    input  logic [31:0] Instruction,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] RsData,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic unused_opcode;
    assign unused_opcode = ^Instruction[31:26];

    // Branch only matters on the sequential path; jumps ignore it.
    always_comb begin
        next_pc = PC_plus4;
        case (PCSrc)
            PCSRC_SEQ: begin
                if (Branch && Zero) begin
                    next_pc = PC_plus4 + branch_offset(Instruction[15:0]);
                end
            end
            PCSRC_J:  next_pc = {PC_plus4[31:28], Instruction[25:0], 2'b00};
            PCSRC_JR: next_pc = RsData;
            default:  next_pc = PC_plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch/PC sequencer: IDLE -> FETCH (req until ack) -> ISSUE (hold until exec_done) -> FETCH.
// Min 2 cycles/instr; IFETCH_ALIGN_CHECK_EN redirects misaligned targets to EXC_VECTOR.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instr_fetch_if.master        imem,
    output logic                 instr_valid,
    output logic [31:0]          Instruction,
    output logic [5:0]           OpCode,
    output logic [5:0]           Funct,
    output logic [31:0]          PC,
    output logic [31:0]          PC_plus4,
    input  logic                 exec_done,
    input  logic [1:0]           PCSrc,
    input  logic                 Branch,
    input  logic                 Zero,
    input  logic [31:0]          RsData,
    output logic [31:0]          retired,
    output logic                 exc
);

    localparam logic [1:0] ST_IDLE  = FS_IDLE;
    localparam logic [1:0] ST_FETCH = FS_FETCH;
    localparam logic [1:0] ST_ISSUE = FS_ISSUE;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic [31:0] pc_load;
    logic        pc_misaligned;
    logic        exec_fire;

    next_pc_calc u_next_pc (
        .PC_plus4    (PC_plus4),
        .Instruction (Instruction),
        .PCSrc       (PCSrc),
        .Branch      (Branch),
        .Zero        (Zero),
        .RsData      (RsData),
        .next_pc     (next_pc),
        .misaligned  (pc_misaligned)
    );

    assign exec_fire = (state == ST_ISSUE) && exec_done;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign pc_load = pc_misaligned ? EXC_VECTOR : next_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc <= 1'b0;
        end else begin
            exc <= exec_fire && pc_misaligned;
        end
    end
`else
    // Misaligned targets are fetched as-is; the vector has no use in this build.
    logic unused_align;
    assign unused_align = pc_misaligned ^ (|EXC_VECTOR);
    assign pc_load      = next_pc;
    assign exc          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            PC          <= RESET_PC;
            Instruction <= 32'h0;
            retired     <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem.ack) begin
                        Instruction <= imem.rdata;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (exec_done) begin
                        PC      <= pc_load;
                        retired <= retired + 32'd1;
                        state   <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Everything below depends only on registers, so no input reaches an output combinationally.
    assign imem.req    = (state == ST_FETCH);
    assign imem.addr   = PC;
    assign instr_valid = (state == ST_ISSUE);
    assign OpCode      = Instruction[31:26];
    assign Funct       = Instruction[5:0];
    assign PC_plus4    = PC + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot, sequential, branch, jumps, wait states, resets, alignment.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        exec_done;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] RsData;
    logic        instr_valid;
    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic [31:0] retired;
    logic        exc;

    int checks  = 0;
    int errors  = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    instr_fetch_if imem ();

    instr_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (imem),
        .instr_valid (instr_valid),
        .Instruction (Instruction),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .PC          (PC),
        .PC_plus4    (PC_plus4),
        .exec_done   (exec_done),
        .PCSrc       (PCSrc),
        .Branch      (Branch),
        .Zero        (Zero),
        .RsData      (RsData),
        .retired     (retired),
        .exc         (exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch of one word, then a single-cycle execute with the given next-PC inputs.
    task automatic run_instr(input logic [31:0] word, input logic [1:0] src, input logic br,
                             input logic z, input logic [31:0] rs, input logic [31:0] exp_pc,
                             input logic [31:0] exp_next, input logic exp_exc);
        chk("fetch_req", {31'b0, imem.req}, 32'd1);
        chk("fetch_addr", imem.addr, exp_pc);
        imem.ack   = 1'b1;
        imem.rdata = word;
        tick();
        imem.ack   = 1'b0;
        imem.rdata = 32'hDEAD_BEEF;
        chk("issue_valid", {31'b0, instr_valid}, 32'd1);
        chk("issue_req", {31'b0, imem.req}, 32'd0);
        chk("issue_instr", Instruction, word);
        chk("issue_opcode", {26'b0, OpCode}, {26'b0, word[31:26]});
        chk("issue_funct", {26'b0, Funct}, {26'b0, word[5:0]});
        chk("issue_pc", PC, exp_pc);
        chk("issue_pc4", PC_plus4, exp_pc + 32'd4);
        chk("issue_exc", {31'b0, exc}, 32'd0);
        exec_done = 1'b1;
        PCSrc     = src;
        Branch    = br;
        Zero      = z;
        RsData    = rs;
        tick();
        exec_done = 1'b0;
        PCSrc     = 2'b00;
        Branch    = 1'b0;
        Zero      = 1'b0;
        RsData    = 32'h0;
        exp_ret++;
        chk("next_addr", imem.addr, exp_next);
        chk("next_valid", {31'b0, instr_valid}, 32'd0);
        chk("retired", retired, exp_ret);
        chk("exc_after", {31'b0, exc}, {31'b0, exp_exc});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mis_next;
        logic        mis_exc;
`ifdef IFETCH_ALIGN_CHECK_EN
        mis_next = 32'h0000_0080;
        mis_exc  = 1'b1;
`else
        mis_next = 32'h0000_0202;
        mis_exc  = 1'b0;
`endif
        reset_n    = 1'b0;
        exec_done  = 1'b0;
        PCSrc      = 2'b00;
        Branch     = 1'b0;
        Zero       = 1'b0;
        RsData     = 32'h0;
        imem.ack   = 1'b0;
        imem.rdata = 32'h0;

        // Reset held for three cycles.
        repeat (3) begin
            tick();
            chk("rst_req", {31'b0, imem.req}, 32'd0);
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        end
        chk("rst_pc", PC, 32'h0);
        chk("rst_pc4", PC_plus4, 32'h4);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_opfunct", {20'b0, OpCode, Funct}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_exc", {31'b0, exc}, 32'd0);

        reset_n = 1'b1;
        chk("idle_req", {31'b0, imem.req}, 32'd0);
        tick();
        chk("boot_req", {31'b0, imem.req}, 32'd1);
        chk("boot_addr", imem.addr, 32'h0);

        // Sequential: Zero high but Branch low must not redirect.
        for (int i = 0; i < 4; i++) begin
            run_instr(32'h8C00_0000 + 32'(i * 3), 2'b00, 1'b0, 1'b1, 32'h0,
                      32'(i * 4), 32'(i * 4 + 4), 1'b0);
        end
        chk("retired4", retired, 32'd4);

        // Branch taken backwards from 0x10: 0x14 + (-4 << 2) = 0x04.
        run_instr(32'h1000_FFFC, 2'b00, 1'b1, 1'b1, 32'h0, 32'h10, 32'h04, 1'b0);
        run_instr(32'h0000_0008, 2'b10, 1'b0, 1'b0, 32'h10, 32'h04, 32'h10, 1'b0);
        // Same branch with Zero low falls through.
        run_instr(32'h1000_FFFC, 2'b00, 1'b1, 1'b0, 32'h0, 32'h10, 32'h14, 1'b0);
        run_instr(32'h0000_0008, 2'b10, 1'b0, 1'b0, 32'h3000_0000, 32'h14, 32'h3000_0000, 1'b0);
        // Jump with Branch&Zero asserted: Branch is ignored.
        run_instr(32'h0800_0040, 2'b01, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3000_0000,
                  32'h3000_0100, 1'b0);
        run_instr(32'h0000_0008, 2'b10, 1'b0, 1'b0, 32'h0000_0200, 32'h3000_0100, 32'h200, 1'b0);
        // Reserved PCSrc falls back to PC+4.
        run_instr(32'h1000_0010, 2'b11, 1'b1, 1'b1, 32'h0000_0500, 32'h200, 32'h204, 1'b0);

        // Three wait states; exec_done during FETCH must be ignored.
        exec_done  = 1'b1;
        imem.rdata = 32'h0123_4567;
        repeat (3) begin
            tick();
            chk("ws_req", {31'b0, imem.req}, 32'd1);
            chk("ws_addr", imem.addr, 32'h204);
            chk("ws_valid", {31'b0, instr_valid}, 32'd0);
        end
        chk("ws_retired", retired, exp_ret);
        exec_done  = 1'b0;
        imem.ack   = 1'b1;
        imem.rdata = 32'h0042_1020;
        tick();
        imem.ack   = 1'b1;
        imem.rdata = 32'hFFFF_FFFF;
        chk("ws_valid_up", {31'b0, instr_valid}, 32'd1);
        chk("ws_instr", Instruction, 32'h0042_1020);
        // ack while issued must not overwrite the held instruction.
        tick();
        imem.ack = 1'b0;
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_instr", Instruction, 32'h0042_1020);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        exp_ret++;
        chk("ws_next", imem.addr, 32'h208);
        chk("ws_retired2", retired, exp_ret);

        // Misaligned register-jump target.
        run_instr(32'h0000_0008, 2'b10, 1'b0, 1'b0, 32'h0000_0202, 32'h208, mis_next, mis_exc);
        tick();
        chk("exc_drop", {31'b0, exc}, 32'd0);
        chk("mis_hold_addr", imem.addr, mis_next);

        // Reset pulsed during an outstanding fetch, with a late ack around release.
        #2;
        reset_n = 1'b0;
        #1;
        chk("mf_req", {31'b0, imem.req}, 32'd0);
        chk("mf_pc", PC, 32'h0);
        chk("mf_retired", retired, 32'h0);
        exp_ret    = 0;
        imem.ack   = 1'b1;
        imem.rdata = 32'hBAD0_BAD0;
        tick();
        reset_n = 1'b1;
        tick();
        imem.ack = 1'b0;
        chk("late_req", {31'b0, imem.req}, 32'd1);
        chk("late_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_addr", imem.addr, 32'h0);
        chk("late_instr", Instruction, 32'h0);

        // Reset while an instruction is issued.
        imem.ack   = 1'b1;
        imem.rdata = 32'h2108_0001;
        tick();
        imem.ack = 1'b0;
        chk("mi_valid", {31'b0, instr_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mi_valid_rst", {31'b0, instr_valid}, 32'd0);
        chk("mi_instr_rst", Instruction, 32'h0);
        chk("mi_pc4_rst", PC_plus4, 32'h4);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mi_reboot_req", {31'b0, imem.req}, 32'd1);
        chk("mi_reboot_addr", imem.addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
